// File: rtl/johnson_counter_updown.sv
// Parametrised up/down Johnson (twisted-ring) counter.
// Adds count enable, direction, load by state index, binary index and
// one-hot decode, terminal-count flag, and illegal-state detection with
// optional auto-correction back to the all-zero state.
module johnson_counter_updown #(
    parameter int WIDTH       = 4,
    parameter bit AUTOCORRECT = 1'b1,
    localparam int IDXW       = $clog2(2 * WIDTH)
) (
    input  logic               clk,
    input  logic               rs,
    input  logic               en,
    input  logic               up,
    input  logic               ld,
    input  logic [IDXW-1:0]    ld_idx,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   qn,
    output logic [IDXW-1:0]    idx,
    output logic [2*WIDTH-1:0] dec,
    output logic               tc,
    output logic               illegal
);

    int               ones;
    int               edges;
    int               ld_k;
    logic [WIDTH-1:0] ld_code;
    logic [WIDTH-1:0] q_next;

    // Classify the current state: number of set bits and number of 0/1 boundaries
    always_comb begin
        ones  = 0;
        edges = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q[i]) ones = ones + 1;
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (q[i] != q[i+1]) edges = edges + 1;
        end
    end

    // A valid Johnson code is a thermometer: at most one boundary
    assign illegal = (edges > 1);

    // Binary index: low-filled codes map to their fill count, high-filled
    // codes map to 2*WIDTH minus their fill count
    always_comb begin
        idx = '0;
        if (!illegal) begin
            if (q[0] || ones == 0) idx = IDXW'(ones);
            else                   idx = IDXW'(2 * WIDTH - ones);
        end
    end

    // One-hot decode of the index, suppressed for illegal patterns
    always_comb begin
        dec = '0;
        if (!illegal) dec = (2 * WIDTH)'(1) << idx;
    end

    // Terminal count flags the cycle before the wrap edge in the active direction
    always_comb begin
        tc = 1'b0;
        if (en && !ld && !illegal) begin
            if (up) tc = (idx == IDXW'(2 * WIDTH - 1));
            else    tc = (idx == '0);
        end
    end

    assign qn = ~q;

    // Build the code for a load index; out-of-range indices load all-zero
    always_comb begin
        ld_k    = int'(ld_idx);
        ld_code = '0;
        if (ld_k <= WIDTH) begin
            for (int i = 0; i < WIDTH; i++) ld_code[i] = (i < ld_k);
        end else if (ld_k < 2 * WIDTH) begin
            for (int i = 0; i < WIDTH; i++) ld_code[i] = (i >= ld_k - WIDTH);
        end
    end

    // Next-state priority: load, then correction, then step, else hold
    always_comb begin
        q_next = q;
        if (ld)                        q_next = ld_code;
        else if (illegal && AUTOCORRECT) q_next = '0;
        else if (en && up)             q_next = {q[WIDTH-2:0], ~q[WIDTH-1]};
        else if (en)                   q_next = {~q[0], q[WIDTH-1:1]};
    end

    // State register with asynchronous reset to the all-zero code
    always_ff @(posedge clk or posedge rs) begin
        if (rs) q <= '0;
        else    q <= q_next;
    end

endmodule

// File: tb/tb_johnson_counter_updown.sv
// Bench for johnson_counter_updown: a 4-bit auto-correcting instance, a 4-bit
// flag-only instance and a 7-bit instance share one set of control inputs.
module tb_johnson_counter_updown;

  logic       clk = 1'b0;
  logic       rs  = 1'b0;
  logic       en  = 1'b0;
  logic       up  = 1'b1;
  logic       ld  = 1'b0;
  logic [2:0] ld_idx4 = '0;
  logic [3:0] ld_idx7 = '0;

  logic [3:0]  q_a, qn_a, q_b, qn_b;
  logic [2:0]  idx_a, idx_b;
  logic [7:0]  dec_a, dec_b;
  logic        tc_a, tc_b, illegal_a, illegal_b;
  logic [6:0]  q_c, qn_c;
  logic [3:0]  idx_c;
  logic [13:0] dec_c;
  logic        tc_c, illegal_c;

  int n_checks = 0;
  int n_errors = 0;
  int m4 = 0;
  int m7 = 0;
  bit b_sync = 1'b1;

  logic [3:0] exp_q[$];
  logic [6:0] exp7_q[$];

  logic [3:0] tbl4 [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};

  johnson_counter_updown #(.WIDTH(4), .AUTOCORRECT(1'b1)) dut_a (
    .clk(clk), .rs(rs), .en(en), .up(up), .ld(ld), .ld_idx(ld_idx4),
    .q(q_a), .qn(qn_a), .idx(idx_a), .dec(dec_a), .tc(tc_a), .illegal(illegal_a)
  );

  johnson_counter_updown #(.WIDTH(4), .AUTOCORRECT(1'b0)) dut_b (
    .clk(clk), .rs(rs), .en(en), .up(up), .ld(ld), .ld_idx(ld_idx4),
    .q(q_b), .qn(qn_b), .idx(idx_b), .dec(dec_b), .tc(tc_b), .illegal(illegal_b)
  );

  johnson_counter_updown #(.WIDTH(7), .AUTOCORRECT(1'b1)) dut_c (
    .clk(clk), .rs(rs), .en(en), .up(up), .ld(ld), .ld_idx(ld_idx7),
    .q(q_c), .qn(qn_c), .idx(idx_c), .dec(dec_c), .tc(tc_c), .illegal(illegal_c)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Johnson code of index k for a w-bit counter
  function automatic logic [15:0] code_w(input int k, input int w);
    logic [15:0] full;
    logic [15:0] low;
    full = (16'd1 << w) - 16'd1;
    if (k <= w) return (16'd1 << k) - 16'd1;
    low = (16'd1 << (k - w)) - 16'd1;
    return full & ~low;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    ld = 1'b0;
    rs = 1'b1;
    #1;
    check("rst_q_a", q_a, 4'h0);
    check("rst_qn_a", qn_a, 4'hF);
    check("rst_idx_a", idx_a, 3'd0);
    check("rst_dec_a", dec_a, 8'h01);
    check("rst_tc_a", tc_a, 1'b0);
    check("rst_illegal_a", illegal_a, 1'b0);
    check("rst_q_b", q_b, 4'h0);
    check("rst_q_c", q_c, 7'h00);
    check("rst_dec_c", dec_c, 14'h0001);
    #1;
    rs = 1'b0;
    m4 = 0;
    m7 = 0;
    b_sync = 1'b1;
  endtask

  task automatic check_outputs();
    logic [3:0] e4;
    logic [3:0] e4n;
    logic [6:0] e7;
    check("pending4", exp_q.size(), 1);
    check("pending7", exp7_q.size(), 1);
    if (exp_q.size() > 0) begin
      e4  = exp_q.pop_front();
      e4n = ~e4;
      check("q_a", q_a, e4);
      check("qn_a", qn_a, e4n);
      check("idx_a", idx_a, m4);
      check("dec_a", dec_a, 8'd1 << m4);
      check("illegal_a", illegal_a, 1'b0);
      if (b_sync) check("q_b", q_b, e4);
    end
    if (exp7_q.size() > 0) begin
      e7 = exp7_q.pop_front();
      check("q_c", q_c, e7);
      check("idx_c", idx_c, m7);
      check("dec_c", dec_c, 14'd1 << m7);
      check("onehot_c", $onehot(dec_c), 1'b1);
      check("illegal_c", illegal_c, 1'b0);
    end
  endtask

  // Drive one cycle of stimulus, predict the next state, check after the edge
  task automatic step(input logic e, input logic u, input logic l,
                      input logic [2:0] li4, input logic [3:0] li7);
    int n4;
    int n7;
    logic [15:0] c7;
    @(negedge clk);
    en = e; up = u; ld = l; ld_idx4 = li4; ld_idx7 = li7;
    #1;
    check("tc_a", tc_a, e & ~l & (u ? (m4 == 7) : (m4 == 0)));
    check("tc_c", tc_c, e & ~l & (u ? (m7 == 13) : (m7 == 0)));
    if (l)      n4 = int'(li4);
    else if (e) n4 = u ? (m4 + 1) % 8 : (m4 + 7) % 8;
    else        n4 = m4;
    if (l)      n7 = (int'(li7) >= 14) ? 0 : int'(li7);
    else if (e) n7 = u ? (m7 + 1) % 14 : (m7 + 13) % 14;
    else        n7 = m7;
    exp_q.push_back(tbl4[n4]);
    c7 = code_w(n7, 7);
    exp7_q.push_back(c7[6:0]);
    @(posedge clk);
    #1;
    m4 = n4;
    m7 = n7;
    check_outputs();
  endtask

  initial begin
    do_reset();

    // free-run up through a full wrap
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 3'd0, 4'd0);

    // load zero, then count down three states
    step(1'b1, 1'b1, 1'b1, 3'd0, 4'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);

    // loads override counting; out-of-range index on the 7-bit instance
    step(1'b1, 1'b1, 1'b1, 3'd5, 4'd10);
    step(1'b1, 1'b0, 1'b1, 3'd2, 4'd15);
    step(1'b1, 1'b1, 1'b1, 3'd7, 4'd14);
    step(1'b1, 1'b1, 1'b0, 3'd0, 4'd0);

    // hold
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 3'd0, 4'd0);

    // random mix of enable, direction and loads
    for (int i = 0; i < 24; i++) begin
      logic       e, u, l;
      logic [2:0] li4;
      logic [3:0] li7;
      e   = ($urandom_range(0, 3) != 0);
      u   = $urandom_range(0, 1);
      l   = ($urandom_range(0, 7) == 0);
      li4 = 3'($urandom_range(0, 7));
      li7 = 4'($urandom_range(0, 15));
      step(e, u, l, li4, li7);
    end

    // asynchronous reset between edges while counting
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
    @(posedge clk);
    #3;
    rs = 1'b1;
    #1;
    check("arst_q_a", q_a, 4'h0);
    check("arst_dec_a", dec_a, 8'h01);
    check("arst_q_c", q_c, 7'h00);
    en = 1'b0;
    rs = 1'b0;
    m4 = 0;
    m7 = 0;
    exp_q.delete();
    exp7_q.delete();
    step(1'b0, 1'b1, 1'b0, 3'd0, 4'd0);

    // illegal pattern on both 4-bit instances
    @(negedge clk);
    en = 1'b1; up = 1'b0; ld = 1'b0;
    force dut_a.q = 4'b0101;
    force dut_b.q = 4'b0101;
    #1;
    check("ill_flag_a", illegal_a, 1'b1);
    check("ill_dec_a", dec_a, 8'h00);
    check("ill_idx_a", idx_a, 3'd0);
    check("ill_tc_a", tc_a, 1'b0);
    check("ill_flag_b", illegal_b, 1'b1);
    en = 1'b0;
    #1;
    release dut_a.q;
    release dut_b.q;
    #1;
    check("ill_keep_a", illegal_a, 1'b1);
    @(posedge clk);
    #1;
    check("fix_q_a", q_a, 4'h0);
    check("fix_ill_a", illegal_a, 1'b0);
    check("hold_q_b", q_b, 4'b0101);
    check("hold_ill_b", illegal_b, 1'b1);
    m4 = 0;
    b_sync = 1'b0;
    step(1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
    check("shift_q_b", q_b, 4'b1011);
    check("shift_ill_b", illegal_b, 1'b1);

    // full 7-bit cycle up then down
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
    check("w7_up_wrap", q_c, 7'h00);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
    check("w7_dn_wrap", q_c, 7'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
